cpu_datapath: RTL and testbench

- 32-bit single-bus datapath of the teaching CPU, driven cycle-by-cycle by the control unit (or a bench) through one-hot register in/out strobes.
- Contains R0–R15, RA, PC, IR, Y, 64-bit Z, HI, LO, MAR, MDR, an output port, the ALU, select/encode logic and a 512×32 word RAM.

---
 rtl/cpu_datapath_if.sv | 35 +++
 rtl/cpu_datapath.sv | 139 +++++++++++++
 tb/tb_cpu_datapath.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Control/data bundle of the teaching-CPU datapath: bus strobes, register loads,
// select/encode controls, ALU opcode and the external data paths.
interface cpu_datapath_if;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic        ra_out, ry_out, rzhi_out, rzlo_out, pc_out, ir_out;
    logic        hi_out, lo_out, mdr_out, mar_out, port_out, c_out;
    logic        ra_in, ry_in, rz_in, pc_in, ir_in, hi_in, lo_in;
    logic        mdr_in, mar_in, port_in;
    logic        read, write;
    logic        gra, grb, grc, rin, rout, ba_out, inc_pc;
    logic [4:0]  ops;
    logic [31:0] mdatain;
    logic [31:0] in_port_data;
    logic [31:0] out_port_data;
    logic [31:0] bus_mux_out;

    modport master (
        output r_out, r_in, ra_out, ry_out, rzhi_out, rzlo_out, pc_out, ir_out,
               hi_out, lo_out, mdr_out, mar_out, port_out, c_out,
               ra_in, ry_in, rz_in, pc_in, ir_in, hi_in, lo_in, mdr_in, mar_in, port_in,
               read, write, gra, grb, grc, rin, rout, ba_out, inc_pc, ops,
               mdatain, in_port_data,
        input  out_port_data, bus_mux_out
    );

    modport slave (
        input  r_out, r_in, ra_out, ry_out, rzhi_out, rzlo_out, pc_out, ir_out,
               hi_out, lo_out, mdr_out, mar_out, port_out, c_out,
               ra_in, ry_in, rz_in, pc_in, ir_in, hi_in, lo_in, mdr_in, mar_in, port_in,
               read, write, gra, grb, grc, rin, rout, ba_out, inc_pc, ops,
               mdatain, in_port_data,
        output out_port_data, bus_mux_out
    );
endinterface

// File: rtl/cpu_datapath.sv
// 32-bit single-bus datapath: register file, special registers, ALU, IR-field
// select/encode, priority bus multiplexer and a word-addressed RAM.
module cpu_datapath #(
    parameter int MEM_DEPTH = 512,
    parameter bit EXT_MEM   = 1'b0
) (
    input logic          clock,
    input logic          clear,
    cpu_datapath_if.slave dp
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] r_reg [16];
    logic [31:0] ra_reg, y_reg, zhi_reg, zlo_reg, pc_reg, ir_reg;
    logic [31:0] hi_reg, lo_reg, mar_reg, mdr_reg, out_reg;
    logic [31:0] mem [MEM_DEPTH];

    logic [31:0] bus, c_sext, mem_word, mdr_next;
    logic [63:0] z_next, rot;
    logic signed [63:0] a64, b64;
    logic [3:0]  sel;
    logic [15:0] sel_onehot, r_drive, r_load;
    logic        ba_zero;

    assign sel        = ({4{dp.gra}} & ir_reg[26:23]) | ({4{dp.grb}} & ir_reg[22:19])
                      | ({4{dp.grc}} & ir_reg[18:15]);
    assign sel_onehot = 16'd1 << sel;
    assign ba_zero    = dp.ba_out && (sel == 4'd0);
    assign c_sext     = {{13{ir_reg[18]}}, ir_reg[18:0]};
    assign mem_word   = EXT_MEM ? dp.mdatain : mem[mar_reg[AW-1:0]];
    assign mdr_next   = dp.read ? mem_word : bus;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sel
            assign r_drive[gi] = dp.r_out[gi] | ((dp.rout | dp.ba_out) & sel_onehot[gi]);
            assign r_load[gi]  = dp.r_in[gi] | (dp.rin & sel_onehot[gi]);
        end
    endgenerate

    // Later assignments override earlier ones, so the list runs lowest priority first.
    always_comb begin
        bus = '0;
        if (dp.c_out)    bus = c_sext;
        if (dp.port_out) bus = dp.in_port_data;
        if (dp.mar_out)  bus = mar_reg;
        if (dp.mdr_out)  bus = mdr_reg;
        if (dp.lo_out)   bus = lo_reg;
        if (dp.hi_out)   bus = hi_reg;
        if (dp.ir_out)   bus = ir_reg;
        if (dp.pc_out)   bus = pc_reg;
        if (dp.rzlo_out) bus = zlo_reg;
        if (dp.rzhi_out) bus = zhi_reg;
        if (dp.ry_out)   bus = y_reg;
        if (dp.ra_out)   bus = ra_reg;
        for (int i = 15; i >= 0; i--) begin
            if (r_drive[i]) bus = (i == 0 && ba_zero) ? 32'd0 : r_reg[i];
        end
    end

    always_comb begin
        z_next = '0;
        rot    = '0;
        a64    = {{32{y_reg[31]}}, y_reg};
        b64    = {{32{bus[31]}}, bus};
        if (dp.inc_pc) begin
            z_next[31:0] = bus + 32'd1;
        end else begin
            case (dp.ops)
                5'b00011: z_next[31:0] = y_reg + bus;
                5'b00100: z_next[31:0] = y_reg - bus;
                5'b01010: z_next[31:0] = y_reg & bus;
                5'b01011: z_next[31:0] = y_reg | bus;
                5'b00101: z_next[31:0] = y_reg >> bus[4:0];
                5'b00110: z_next[31:0] = $signed(y_reg) >>> bus[4:0];
                5'b00111: z_next[31:0] = y_reg << bus[4:0];
                5'b01000: begin
                    rot          = {y_reg, y_reg} >> bus[4:0];
                    z_next[31:0] = rot[31:0];
                end
                5'b01001: begin
                    rot          = {y_reg, y_reg} << bus[4:0];
                    z_next[31:0] = rot[63:32];
                end
                5'b01100: z_next = a64 * b64;
                5'b01101: begin
                    if (bus != 32'd0) begin
                        z_next[31:0]  = $signed(y_reg) / $signed(bus);
                        z_next[63:32] = $signed(y_reg) % $signed(bus);
                    end
                end
                5'b01110: z_next[31:0] = 32'd0 - bus;
                5'b01111: z_next[31:0] = ~bus;
                default:  z_next = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_reg[i] <= '0;
            ra_reg  <= '0;
            y_reg   <= '0;
            zhi_reg <= '0;
            zlo_reg <= '0;
            pc_reg  <= '0;
            ir_reg  <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            mar_reg <= '0;
            mdr_reg <= '0;
            out_reg <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_load[i]) r_reg[i] <= bus;
            end
            if (dp.ra_in)   ra_reg  <= bus;
            if (dp.ry_in)   y_reg   <= bus;
            if (dp.pc_in)   pc_reg  <= bus;
            if (dp.ir_in)   ir_reg  <= bus;
            if (dp.hi_in)   hi_reg  <= bus;
            if (dp.lo_in)   lo_reg  <= bus;
            if (dp.mar_in)  mar_reg <= bus;
            if (dp.port_in) out_reg <= bus;
            if (dp.mdr_in)  mdr_reg <= mdr_next;
            if (dp.rz_in) begin
                zhi_reg <= z_next[63:32];
                zlo_reg <= z_next[31:0];
            end
        end
    end

    // RAM is not reset; a simultaneous read sees the pre-write word.
    always_ff @(posedge clock) begin
        if (dp.write) mem[mar_reg[AW-1:0]] <= mdr_reg;
    end

    assign dp.out_port_data = out_reg;
    assign dp.bus_mux_out   = bus;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: a behavioural model predicts bus and output
// port every cycle; literal expectations pin the key results.
module tb_cpu_datapath;
    localparam int R_O = 0,  RA_O = 16, Y_O = 17, ZHI_O = 18, ZLO_O = 19, PC_O = 20;
    localparam int IR_O = 21, HI_O = 22, LO_O = 23, MDR_O = 24, MAR_O = 25, PORT_O = 26, C_O = 27;
    localparam int R_I = 28, RA_I = 44, Y_I = 45, Z_I = 46, PC_I = 47, IR_I = 48, HI_I = 49;
    localparam int LO_I = 50, MDR_I = 51, MAR_I = 52, PORT_I = 53, READ = 54, WRITE = 55;
    localparam int GRA = 56, GRB = 57, GRC = 58, RIN = 59, ROUT = 60, BA = 61, INC = 62;

    logic clock, clear;
    cpu_datapath_if ifc ();
    cpu_datapath #(.MEM_DEPTH(512), .EXT_MEM(1'b0)) dut (.clock(clock), .clear(clear), .dp(ifc));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int errors = 0;
    int checks = 0;
    int ncyc = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_ra, m_y, m_zhi, m_zlo, m_pc, m_ir, m_hi, m_lo, m_mar, m_mdr, m_out;
    logic [31:0] m_mem [512];
    logic [31:0] exp_bus, bus_last;
    logic        valid = 1'b0;

    function automatic logic [63:0] B(input int i);
        return 64'd1 << i;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
        m_ra = 0; m_y = 0; m_zhi = 0; m_zlo = 0; m_pc = 0; m_ir = 0;
        m_hi = 0; m_lo = 0; m_mar = 0; m_mdr = 0; m_out = 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [63:0] s);
        logic [3:0] v;
        v = 4'd0;
        if (s[GRA]) v = v | m_ir[26:23];
        if (s[GRB]) v = v | m_ir[22:19];
        if (s[GRC]) v = v | m_ir[18:15];
        return v;
    endfunction

    // Walk the sources in priority order; the first one asserted owns the bus.
    function automatic logic [31:0] m_bus(input logic [63:0] s);
        int sl;
        sl = int'(m_sel(s));
        for (int i = 0; i < 16; i++) begin
            if (s[R_O+i] || ((s[ROUT] || s[BA]) && sl == i))
                return (i == 0 && s[BA] && sl == 0) ? 32'd0 : m_r[i];
        end
        if (s[RA_O])   return m_ra;
        if (s[Y_O])    return m_y;
        if (s[ZHI_O])  return m_zhi;
        if (s[ZLO_O])  return m_zlo;
        if (s[PC_O])   return m_pc;
        if (s[IR_O])   return m_ir;
        if (s[HI_O])   return m_hi;
        if (s[LO_O])   return m_lo;
        if (s[MDR_O])  return m_mdr;
        if (s[MAR_O])  return m_mar;
        if (s[PORT_O]) return ifc.in_port_data;
        if (s[C_O])    return {{13{m_ir[18]}}, m_ir[18:0]};
        return 32'd0;
    endfunction

    function automatic logic [63:0] m_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic inc);
        longint sa, sb;
        int q, r, ia;
        logic [31:0] t;
        if (inc) return {32'd0, b + 32'd1};
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ia = int'(a);
        t  = a;
        case (op)
            5'd3:  return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd10: return {32'd0, a & b};
            5'd11: return {32'd0, a | b};
            5'd5:  return {32'd0, a >> b[4:0]};
            5'd6:  return {32'd0, 32'(ia >>> b[4:0])};
            5'd7:  return {32'd0, a << b[4:0]};
            5'd8:  begin repeat (int'(b[4:0])) t = {t[0], t[31:1]}; return {32'd0, t}; end
            5'd9:  begin repeat (int'(b[4:0])) t = {t[30:0], t[31]}; return {32'd0, t}; end
            5'd12: return 64'(sa * sb);
            5'd13: begin
                if (b == 32'd0) return 64'd0;
                q = ia / int'(b);
                r = ia % int'(b);
                return {32'(r), 32'(q)};
            end
            5'd14: return {32'd0, -b};
            5'd15: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic drive(input logic [63:0] s, input logic [4:0] op);
        ifc.r_out = s[15:0];
        ifc.ra_out = s[RA_O]; ifc.ry_out = s[Y_O]; ifc.rzhi_out = s[ZHI_O]; ifc.rzlo_out = s[ZLO_O];
        ifc.pc_out = s[PC_O]; ifc.ir_out = s[IR_O]; ifc.hi_out = s[HI_O]; ifc.lo_out = s[LO_O];
        ifc.mdr_out = s[MDR_O]; ifc.mar_out = s[MAR_O]; ifc.port_out = s[PORT_O]; ifc.c_out = s[C_O];
        ifc.r_in = s[43:28];
        ifc.ra_in = s[RA_I]; ifc.ry_in = s[Y_I]; ifc.rz_in = s[Z_I]; ifc.pc_in = s[PC_I];
        ifc.ir_in = s[IR_I]; ifc.hi_in = s[HI_I]; ifc.lo_in = s[LO_I]; ifc.mdr_in = s[MDR_I];
        ifc.mar_in = s[MAR_I]; ifc.port_in = s[PORT_I]; ifc.read = s[READ]; ifc.write = s[WRITE];
        ifc.gra = s[GRA]; ifc.grb = s[GRB]; ifc.grc = s[GRC]; ifc.rin = s[RIN];
        ifc.rout = s[ROUT]; ifc.ba_out = s[BA]; ifc.inc_pc = s[INC]; ifc.ops = op;
    endtask

    // One clock: drive, predict, let the compare process check at the falling edge, update model.
    task automatic cyc(input logic [63:0] s, input logic [4:0] op);
        logic [31:0] b, old_mdr, old_mar, word;
        logic [63:0] z;
        logic [3:0]  sl;
        drive(s, op);
        b  = m_bus(s);
        sl = m_sel(s);
        z  = m_alu(op, m_y, b, s[INC]);
        exp_bus = b;
        valid = 1'b1;
        @(negedge clock);
        bus_last = ifc.bus_mux_out;
        @(posedge clock);
        valid = 1'b0;
        old_mdr = m_mdr;
        old_mar = m_mar;
        word = m_mem[old_mar[8:0]];
        for (int i = 0; i < 16; i++) if (s[R_I+i] || (s[RIN] && int'(sl) == i)) m_r[i] = b;
        if (s[RA_I])   m_ra = b;
        if (s[Y_I])    m_y = b;
        if (s[PC_I])   m_pc = b;
        if (s[IR_I])   m_ir = b;
        if (s[HI_I])   m_hi = b;
        if (s[LO_I])   m_lo = b;
        if (s[MAR_I])  m_mar = b;
        if (s[PORT_I]) m_out = b;
        if (s[Z_I])    {m_zhi, m_zlo} = z;
        if (s[MDR_I])  m_mdr = s[READ] ? word : b;
        if (s[WRITE])  m_mem[old_mar[8:0]] = old_mdr;
        ncyc++;
        $display("cyc %0d ctl=%h ops=%b bus=%h out=%h", ncyc, s, op, bus_last, ifc.out_port_data);
        #1;
    endtask

    always @(negedge clock) begin
        if (valid) begin
            checks++;
            if (ifc.bus_mux_out !== exp_bus) begin
                errors++;
                $display("FAIL model_bus cyc %0d: got %h expected %h", ncyc + 1, ifc.bus_mux_out, exp_bus);
            end
            checks++;
            if (ifc.out_port_data !== m_out) begin
                errors++;
                $display("FAIL model_outport cyc %0d: got %h expected %h", ncyc + 1, ifc.out_port_data, m_out);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rdchk(input string nm, input int idx, input logic [31:0] exp);
        cyc(B(idx), 5'd0);
        chk(nm, bus_last, exp);
    endtask

    task automatic put(input int dst, input logic [31:0] v);
        ifc.in_port_data = v;
        cyc(B(PORT_O) | B(dst), 5'd0);
    endtask

    typedef struct {
        logic [31:0] y, b;
        logic [4:0]  op;
        logic [31:0] zhi, zlo;
    } alu_vec_t;

    alu_vec_t tbl [16] = '{
        '{32'hFFFFFFFF, 32'd2,        5'b01100, 32'hFFFFFFFF, 32'hFFFFFFFE},
        '{32'd7,        32'd2,        5'b01101, 32'd1,        32'd3},
        '{32'd7,        32'd2,        5'b00100, 32'd0,        32'd5},
        '{32'd7,        32'd1,        5'b01000, 32'd0,        32'h80000003},
        '{32'h80000001, 32'd1,        5'b01001, 32'd0,        32'd3},
        '{32'h80000000, 32'd4,        5'b00101, 32'd0,        32'h08000000},
        '{32'h80000000, 32'd4,        5'b00110, 32'd0,        32'hF8000000},
        '{32'd1,        32'h21,       5'b00111, 32'd0,        32'd2},
        '{32'hF0F0,     32'hFF00,     5'b01010, 32'd0,        32'hF000},
        '{32'hF0F0,     32'h0F0F,     5'b01011, 32'd0,        32'hFFFF},
        '{32'hFFFFFFFF, 32'd1,        5'b00011, 32'd0,        32'd0},
        '{32'd0,        32'd1,        5'b01110, 32'd0,        32'hFFFFFFFF},
        '{32'd0,        32'd0,        5'b01111, 32'd0,        32'hFFFFFFFF},
        '{32'hFFFFFFF9, 32'd2,        5'b01101, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{32'd7,        32'd0,        5'b01101, 32'd0,        32'd0},
        '{32'd7,        32'd2,        5'b11111, 32'd0,        32'd0}
    };

    initial begin
        for (int i = 0; i < 512; i++) m_mem[i] = 32'd0;
        model_reset();
        ifc.mdatain = 32'd0;
        ifc.in_port_data = 32'd0;
        drive(64'd0, 5'd0);
        clear = 1'b0;
        #12 clear = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_outport", ifc.out_port_data, 32'd0);
        rdchk("reset_pc", PC_O, 32'd0);

        // Asynchronous clear between edges.
        put(R_I + 5, 32'h1234);
        put(PC_I, 32'd7);
        rdchk("r5_loaded", R_O + 5, 32'h1234);
        rdchk("pc_loaded", PC_O, 32'd7);
        #1 clear = 1'b0;
        model_reset();
        drive(64'd0, 5'd0);
        #1 chk("clear_bus_idle", ifc.bus_mux_out, 32'd0);
        ifc.r_out = 16'h0020;
        #1 chk("clear_r5", ifc.bus_mux_out, 32'd0);
        ifc.r_out = 16'h0000; ifc.pc_out = 1'b1;
        #1 chk("clear_pc", ifc.bus_mux_out, 32'd0);
        ifc.pc_out = 1'b0; ifc.rzlo_out = 1'b1;
        #1 chk("clear_zlo", ifc.bus_mux_out, 32'd0);
        ifc.rzlo_out = 1'b0;
        #3 clear = 1'b1;
        @(posedge clock);
        #1;

        // Preload RAM[0] through MDR, then fetch.
        put(MDR_I, 32'h10900014);
        cyc(B(WRITE), 5'd0);
        put(MDR_I, 32'd0);
        cyc(B(PC_O) | B(MAR_I) | B(INC) | B(Z_I), 5'd0);
        rdchk("fetch_zlo", ZLO_O, 32'd1);
        rdchk("fetch_mar", MAR_O, 32'd0);
        cyc(B(ZLO_O) | B(PC_I) | B(READ) | B(MDR_I), 5'd0);
        rdchk("fetch_pc", PC_O, 32'd1);
        rdchk("fetch_mdr", MDR_O, 32'h10900014);
        cyc(B(MDR_O) | B(IR_I), 5'd0);
        rdchk("fetch_ir", IR_O, 32'h10900014);

        // Store R1 to C + R2.
        put(R_I + 1, 32'h55);
        put(R_I + 2, 32'h10);
        cyc(B(GRB) | B(BA) | B(Y_I), 5'd0);
        rdchk("st_y", Y_O, 32'h10);
        cyc(B(C_O) | B(Z_I), 5'b00011);
        rdchk("st_zlo", ZLO_O, 32'h24);
        cyc(B(ZLO_O) | B(MAR_I), 5'd0);
        cyc(B(GRA) | B(ROUT) | B(MDR_I), 5'd0);
        rdchk("st_mdr", MDR_O, 32'h55);
        cyc(B(WRITE), 5'd0);
        put(MDR_I, 32'd0);
        cyc(B(READ) | B(MDR_I), 5'd0);
        rdchk("st_ram", MDR_O, 32'h55);
        put(MDR_I, 32'h77);
        cyc(B(READ) | B(WRITE) | B(MDR_I), 5'd0);
        rdchk("rw_old_word", MDR_O, 32'h55);
        cyc(B(READ) | B(MDR_I), 5'd0);
        rdchk("rw_new_word", MDR_O, 32'h77);

        // Priority: R1 beats PC and C; nothing asserted gives 0.
        cyc(B(R_O + 1) | B(PC_O) | B(C_O), 5'd0);
        chk("prio_r1", bus_last, 32'h55);
        cyc(B(HI_O) | B(MAR_O), 5'd0);
        chk("prio_hi_over_mar", bus_last, 32'd0);
        cyc(64'd0, 5'd0);
        chk("bus_idle", bus_last, 32'd0);

        // BAout with Rb=0, rin via Rc, sign-extended C.
        put(IR_I, 32'h00040000);
        put(R_I + 0, 32'hFF);
        cyc(B(GRB) | B(BA) | B(Y_I), 5'd0);
        rdchk("ba_r0_zero", Y_O, 32'd0);
        cyc(B(GRB) | B(ROUT) | B(Y_I), 5'd0);
        rdchk("rout_r0", Y_O, 32'hFF);
        ifc.in_port_data = 32'hCAFE;
        cyc(B(PORT_O) | B(GRC) | B(RIN), 5'd0);
        rdchk("rin_r8", R_O + 8, 32'hCAFE);
        rdchk("sext_c", C_O, 32'hFFFC0000);

        // ALU table.
        foreach (tbl[i]) begin
            put(Y_I, tbl[i].y);
            ifc.in_port_data = tbl[i].b;
            cyc(B(PORT_O) | B(Z_I), tbl[i].op);
            rdchk($sformatf("alu%0d_zhi", i), ZHI_O, tbl[i].zhi);
            rdchk($sformatf("alu%0d_zlo", i), ZLO_O, tbl[i].zlo);
        end
        put(Y_I, 32'hFFFFFFFF);
        ifc.in_port_data = 32'd2;
        cyc(B(PORT_O) | B(Z_I), 5'b01100);
        cyc(B(ZHI_O) | B(HI_I), 5'd0);
        cyc(B(ZLO_O) | B(LO_I), 5'd0);
        rdchk("hi_reg", HI_O, 32'hFFFFFFFF);
        rdchk("lo_reg", LO_O, 32'hFFFFFFFE);

        // Output port.
        put(PORT_I, 32'hABCD);
        chk("outport", ifc.out_port_data, 32'hABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
